// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WE_WORD  = 4'hF;
  localparam logic [3:0] WE_BYTE0 = 4'h1;

  localparam logic CORE   = 1'b0;
  localparam logic LOADER = 1'b1;

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering between a latched request and the 32-bit memory bus.
module lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic        byte_sel,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata
);

  logic [7:0] rd_lane;

  always_comb begin
    mem_we    = '0;
    mem_wdata = wdata;
    rdata     = mem_rdata;
    rd_lane   = mem_rdata[8*byte_off +: 8];
    if (byte_sel) begin
      // Byte stores replicate onto every lane; the strobe picks the target.
      mem_wdata = {4{wdata[7:0]}};
      rdata     = {24'b0, rd_lane};
    end
    if (we) begin
      mem_we = byte_sel ? (WE_BYTE0 << byte_off) : WE_WORD;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the core (port 0) and the loader (port 1).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        gnt_id,
  output logic        busy,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic            byte_q, byte_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel;
  logic [3:0]      lane_we;
  logic [31:0]     lane_rdata;

  lane_align u_lane_align (
    .byte_off  (addr_q[1:0]),
    .byte_sel  (byte_q),
    .we        (we_q),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .mem_we    (lane_we),
    .mem_wdata (mem_wdata),
    .rdata     (lane_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ~FIRST_PRIO;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // On contention the port that did not win last time goes first.
    sel     = (req == 2'b11) ? ~last_q : (req[CORE] ? CORE : LOADER);
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = we[sel];
          byte_d  = byte_sel[sel];
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          cnt_d   = '0;
          if (!byte_sel[sel] && (addr_d[1:0] != 2'b00)) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : lane_rdata;
        end else if (cnt_q == CntLast) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state_q == RESP) ack[gnt_q] = 1'b1;
  end

  assign busy     = (state_q != IDLE);
  assign mem_en   = (state_q == ACCESS);
  assign err      = (state_q == RESP) && err_q;
  assign rdata    = rdata_q;
  assign gnt_id   = gnt_q;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_we   = mem_en ? lane_we : 4'b0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random/directed bench for mem_arbiter with a transaction-level memory model.
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk, rst;
  logic [1:0]  req, we, byte_sel;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  ack;
  logic        err, gnt_id, busy, mem_en, mem_ready;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .FIRST_PRIO(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .byte_sel  (byte_sel),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          en;
    bit          has_mem;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          order_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] phys[64];
  int          ws_port[2];
  bit          model_last;
  int          n_pass, n_total;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [127:0] outs();
    return {22'b0, ack, err, rdata, gnt_id, busy, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  // Reference model: serialised memory semantics, evaluated when a request is issued.
  task automatic model_push(input int p, input bit w, input bit b, input logic [31:0] a,
                            input logic [31:0] d, input int wsv, output int lat);
    exp_t e;
    int idx = int'(a[7:2]);
    int off = int'(a[1:0]);
    e.err = 1'b0; e.rdata = '0; e.en = 0; e.has_mem = 1'b0; e.wr = w;
    e.addr = a & 32'hFFFF_FFFC; e.we = 4'h0; e.wdata = '0;
    if (!b && off != 0) begin
      e.err = 1'b1;
      lat = 1;
    end else begin
      e.has_mem = 1'b1;
      if (w) begin
        e.we    = b ? 4'(1 << off) : 4'hF;
        e.wdata = b ? {d[7:0], d[7:0], d[7:0], d[7:0]} : d;
      end
      if (wsv >= TIMEOUT) begin
        e.err = 1'b1;
        e.en  = TIMEOUT;
        lat   = TIMEOUT + 1;
      end else begin
        e.en = wsv + 1;
        lat  = wsv + 2;
        if (w) begin
          if (b) ref_mem[idx][8*off +: 8] = d[7:0];
          else ref_mem[idx] = d;
        end else begin
          e.rdata = b ? ((ref_mem[idx] >> (8 * off)) & 32'hFF) : ref_mem[idx];
        end
      end
    end
    if (p == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic do_txn(input int p, input bit w, input bit b, input logic [31:0] a,
                        input logic [31:0] d, input int wsv, input bit chk_lat);
    int lat, n;
    bit got;
    model_push(p, w, b, a, d, wsv, lat);
    ws_port[p]  = wsv;
    we[p]       = w;
    byte_sel[p] = b;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    req[p] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (ack[p]) got = 1'b1;
    end
    req[p] = 1'b0;
    if (chk_lat || !got) check($sformatf("latency_p%0d", p), 128'(n), 128'(lat));
  endtask

  task automatic seq(input int p, input bit w, input bit b, input logic [31:0] a,
                     input logic [31:0] d, input int wsv);
    do_txn(p, w, b, a, d, wsv, 1'b1);
    model_last = p[0];
    @(negedge clk);
  endtask

  task automatic gen(input int p, output bit w, output bit b, output logic [31:0] a,
                     output logic [31:0] d, output int wsv);
    int idx, off, r;
    w   = 1'($urandom_range(0, 1));
    b   = 1'($urandom_range(0, 1));
    idx = p * 16 + int'($urandom_range(0, 15));
    off = int'($urandom_range(0, 3));
    if (!b && $urandom_range(0, 3) != 0) off = 0;
    a   = 32'(idx * 4 + off);
    d   = $urandom;
    r   = int'($urandom_range(0, 11));
    wsv = (r == 10) ? 20 : (r == 11) ? TIMEOUT - 1 : r % 4;
  endtask

  // Memory responder: the wait-state count of the owning port decides when mem_ready fires.
  task automatic responder();
    int acc = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_en) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        acc = 0;
      end else begin
        if (acc == ws_port[gnt_id]) begin
          mem_ready = 1'b1;
          for (int l = 0; l < 4; l++)
            if (mem_we[l]) phys[mem_addr[7:2]][8*l +: 8] = mem_wdata[8*l +: 8];
          mem_rdata = (mem_we != 4'h0) ? $urandom : phys[mem_addr[7:2]];
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        acc++;
      end
    end
  endtask

  task automatic monitor();
    int en_cnt = 0;
    int p;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [3:0] s_we = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_cnt = 0;
        continue;
      end
      if (mem_en) begin
        en_cnt++;
        s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
      end
      if (ack != 2'b00) begin
        p = ack[1] ? 1 : 0;
        check("ack_onehot", 128'($countones(ack)), 128'd1);
        check("gnt_id_at_ack", 128'(gnt_id), 128'(p));
        check("busy_at_ack", 128'(busy), 128'd1);
        if (order_q.size() > 0) check("grant_order", 128'(p), 128'(order_q.pop_front()));
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
          check("unexpected_ack", 128'(ack), 128'd0);
        end else begin
          e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("err_p%0d", p), 128'(err), 128'(e.err));
          check($sformatf("rdata_p%0d", p), 128'(rdata), 128'(e.rdata));
          check($sformatf("mem_en_cycles_p%0d", p), 128'(en_cnt), 128'(e.en));
          if (e.has_mem) begin
            check("mem_addr", 128'(s_addr), 128'(e.addr));
            check("mem_we", 128'(s_we), 128'(e.we));
            if (e.wr) check("mem_wdata", 128'(s_wdata), 128'(e.wdata));
          end
        end
        en_cnt = 0;
      end
    end
  endtask

  task automatic stimulus();
    bit w0, b0, w1, b1;
    logic [31:0] a0, d0, a1, d1;
    int ws0, ws1, sel, s, n;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", outs(), '0);

    // Directed core traffic.
    seq(0, 1'b0, 1'b0, 32'h10, 32'h0, 0);
    seq(0, 1'b1, 1'b0, 32'h10, 32'h7F00_0000, 1);
    seq(0, 1'b0, 1'b1, 32'h13, 32'h0, 0);
    seq(0, 1'b1, 1'b1, 32'h13, 32'h0000_00A5, 0);
    seq(0, 1'b0, 1'b0, 32'h10, 32'h0, 0);
    seq(0, 1'b0, 1'b0, 32'h22, 32'h0, 0);
    seq(0, 1'b0, 1'b0, 32'h10, 32'h0, 100);
    seq(0, 1'b0, 1'b0, 32'h10, 32'h0, TIMEOUT - 1);
    seq(1, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 1);
    seq(1, 1'b0, 1'b1, 32'h41, 32'h0, 2);

    // Both ports requesting back to back: grants must alternate.
    s = model_last ? 0 : 1;
    for (int i = 0; i < 8; i++) order_q.push_back((i % 2 == 0) ? s : 1 - s);
    fork
      for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 1'b0, 32'(4 * i), 32'h0, 2, 1'b0);
      for (int j = 0; j < 4; j++) do_txn(1, 1'b1, 1'b0, 32'(32'h44 + 4 * j), $urandom, 2, 1'b0);
    join
    @(negedge clk);

    // Reset in the middle of a stalled access drops it silently.
    ws_port[0] = 100; we[0] = 1'b0; byte_sel[0] = 1'b0; addr0 = 32'h10;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", outs(), '0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    check("idle_after_mid_reset", outs(), '0);

    // First contention after reset goes to port 0.
    order_q.push_back(0);
    order_q.push_back(1);
    fork
      do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
      do_txn(1, 1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0);
    join
    @(negedge clk);
    seq(0, 1'b0, 1'b1, 32'h12, 32'h0, 0);

    // Random mix.
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 2));
      gen(0, w0, b0, a0, d0, ws0);
      gen(1, w1, b1, a1, d1, ws1);
      if (sel == 2) begin
        s = model_last ? 0 : 1;
        order_q.push_back(s);
        order_q.push_back(1 - s);
        fork
          do_txn(0, w0, b0, a0, d0, ws0, 1'b0);
          do_txn(1, w1, b1, a1, d1, ws1, 1'b0);
        join
        @(negedge clk);
      end else if (sel == 0) begin
        seq(0, w0, b0, a0, d0, ws0);
      end else begin
        seq(1, w1, b1, a1, d1, ws1);
      end
    end

    n = 0;
    while ((exp_q0.size() + exp_q1.size() + order_q.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 128'(exp_q0.size() + exp_q1.size() + order_q.size()), '0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    req = '0; we = '0; byte_sel = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    ws_port[0] = 0; ws_port[1] = 0;
    model_last = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      phys[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    phys[4] = 32'hDEAD_BEEF;
    fork
      responder();
      monitor();
      begin
        stimulus();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    join
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters. Port 0 is the multicycle core: fetch, lw/sw/lbu/sb. Port 1 is the program loader/debug port.
- Serialises accesses with a req/ack handshake and a registered three-state FSM.
- Performs byte-lane steering for byte stores/loads, rejects misaligned word accesses, and times out stalled memory accesses.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready before abort (>=2)
- FIRST_PRIO, 0, port that wins the first simultaneous request after reset (0 or 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  request per port (bit0 core, bit1 loader); held until ack
- we  in  2  per-port write enable
- byte_sel  in  2  per-port access size: 1 = byte (lbu/sb), 0 = word (lw/sw/fetch)
- addr0, addr1  in  32 each  per-port byte address
- wdata0, wdata1  in  32 each  per-port store data; byte stores use bits [7:0]
- ack  out  2  one-cycle completion pulse to the granted port
- err  out  1  valid with ack: misaligned word access or timeout
- rdata  out  32  load result, valid with ack; 0 for writes and errors
- gnt_id  out  1  port currently owning memory; valid while busy
- busy  out  1  FSM not in IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte write strobes
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, all outputs 0.
  - last_gnt = ~FIRST_PRIO.
  - Timeout counter 0.
  - An in-flight transaction is dropped with no ack.
- IDLE:
  - Single request: grant it.
  - Both requests: grant the port != last_gnt (round-robin). Update last_gnt and gnt_id.
  - Latch we, byte_sel, addr and wdata of the granted port.
  - Word access with addr[1:0]!=0: go to RESP with err=1. No mem_en.
  - Otherwise: go to ACCESS with mem_en=1 on the next cycle.
- ACCESS:
  - mem_en=1 and all mem_* outputs stable; counter increments each cycle.
  - mem_ready=1: capture data, go to RESP.
  - Counter reaches TIMEOUT-1 without mem_ready: drop mem_en, go to RESP with err=1.
  - mem_ready in the same cycle as the timeout: ready wins.
- RESP:
  - ack[gnt_id]=1 for exactly one cycle; then go to IDLE and clear the counter.
  - req is ignored in RESP. A req still high in IDLE is a new request.
- Latency: req sampled at cycle N, mem_en at N+1, ack at N+2 with zero wait states. Each wait state adds 1 cycle.
- Write lanes:
  - Word: mem_we=4'b1111, mem_wdata=wdata.
  - Byte: mem_we=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - Reads: mem_we=0.
- Read data:
  - Word: rdata=mem_rdata.
  - Byte: rdata={24'b0, selected lane}, lane = addr[1:0] (0 → bits [7:0], 3 → bits [31:24]). Zero-extended per lbu.
  - rdata is registered and held until the next ack.
- Protocol violation: req dropped before ack. The transaction still completes and ack still pulses; no error is flagged.
- A byte access at any address is legal.
- A new grant is never issued while busy. Starvation is impossible: with both ports requesting continuously, grants alternate.

Decomposition:
- Package mem_arb_pkg:
  - State encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Constants WE_WORD=4'hF, WE_BYTE0=4'h1.
  - Port indices CORE=0, LOADER=1.
- Sub-module lane_align (combinational):
  - Store path: addr[1:0], byte_sel, wdata → mem_we, mem_wdata.
  - Load path: mem_rdata → rdata.
  - Instantiated once, fed from the latched request.

Test Plan:
- Core lw, addr0=32'h10, mem_ready same cycle, mem_rdata=32'hDEADBEEF → mem_addr=32'h10 at N+1, ack=2'b01 at N+2, rdata=32'hDEADBEEF, err=0.
- Core sb, addr0=32'h13, wdata0=32'h000000A5 → mem_we=4'b1000, mem_wdata=32'hA5A5A5A5. Core lbu at 32'h13 with mem_rdata=32'h7F000000 → rdata=32'h0000007F.
- Both ports request continuously, two wait states each → gnt_id sequence 0,1,0,1. Each ack arrives 4 cycles after its grant.
- Core lw at addr0=32'h22 → no mem_en, ack=2'b01 at N+1, err=1, rdata=0.
- mem_ready held low, TIMEOUT=16 → mem_en high 16 cycles, then ack with err=1. With mem_ready asserted on the final ACCESS cycle → err=0.
- Assert rst during ACCESS → all outputs 0 immediately, no ack. First request after release is served normally.
